// File: rtl/video_udp_packetizer_pkg.sv
// Shared definitions for the video line packetizer: header tag, FSM state
// encodings and the UDP payload length helper.
package video_udp_packetizer_pkg;

  localparam logic [7:0] HDR_TAG = 8'hA5;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_BUSY,
    TX_GAP
  } tx_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_PAD
  } wr_state_t;

  // Payload = one 32-bit header word plus two bytes per RGB565 pixel.
  function automatic logic [15:0] calc_tx_byte_num(input int unsigned h_pixels);
    return 16'(4 + 2 * h_pixels);
  endfunction

endpackage

// File: rtl/video_udp_packetizer_if.sv
// Bundle of the video input and UDP transmitter side signals.
//   vs_in, de_in, pix_data     : video timing and RGB565 pixel
//   udp_tx_start_en            : one-cycle packet start pulse
//   tx_byte_num                : UDP payload length
//   tx_req / tx_data           : payload word read handshake
//   udp_tx_done                : end-of-packet pulse
//   line_drop_cnt              : saturating count of dropped lines
// master = video source / UDP transmitter side, slave = packetizer.
interface video_udp_packetizer_if;
  logic        vs_in;
  logic        de_in;
  logic [15:0] pix_data;
  logic        udp_tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic [31:0] tx_data;
  logic        udp_tx_done;
  logic [15:0] line_drop_cnt;

  modport master (
    output vs_in, de_in, pix_data, tx_req, udp_tx_done,
    input  udp_tx_start_en, tx_byte_num, tx_data, line_drop_cnt
  );

  modport slave (
    input  vs_in, de_in, pix_data, tx_req, udp_tx_done,
    output udp_tx_start_en, tx_byte_num, tx_data, line_drop_cnt
  );
endinterface

// File: rtl/sync_fifo_32.sv
// Single-clock 32-bit FIFO, registered read data (1-cycle latency).
//   clk, rst_n         : clock, async active-low reset
//   wr_en, wr_data     : write port (ignored when full)
//   rd_en, rd_data     : read port; rd_data updates only on a real pop
//   used               : number of stored words
//   empty              : no words stored
module sync_fifo_32 #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  input  logic                     rd_en,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   used,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty = (used == '0);
  assign do_wr = wr_en && (used != FULL_CNT);
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      used    <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      used <= used + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/video_udp_packetizer.sv
// Packs each video line into one UDP payload: a header word
// {A5, frame_cnt, line_cnt} followed by H_PIXELS/2 pixel-pair words.
// Lines are buffered in a FIFO and announced to the UDP transmitter with a
// start pulse; packets are spaced by IFG_CYCLES idle cycles after done.
//   clk, rst_n : clock, async active-low reset
//   bus        : video input + UDP transmitter handshake (slave modport)
//
// Sender FSM
//   state    | meaning
//   TX_IDLE  | wait for a complete line in the FIFO
//   TX_START | one-cycle udp_tx_start_en, consume one ready line
//   TX_BUSY  | transmitter reading payload, wait for udp_tx_done
//   TX_GAP   | inter-frame gap down-counter running
// Writer FSM
//   state    | meaning
//   WR_IDLE  | waiting for a de_in rising edge
//   WR_DATA  | packing pixel pairs of an accepted line
//   WR_PAD   | short line, writing zero words up to full length
module video_udp_packetizer
  import video_udp_packetizer_pkg::*;
#(
  parameter int H_PIXELS   = 640,
  parameter int FIFO_DEPTH = 1024,
  parameter int IFG_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  video_udp_packetizer_if.slave  bus
);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int LINE_WORDS = H_PIXELS / 2;
  localparam logic [AW:0] NEED_FREE = (AW+1)'(LINE_WORDS + 1);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [8:0]  LAST_WORD = 9'(LINE_WORDS - 1);
  localparam logic [15:0] GAP_LOAD  = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

  logic        vs_d, de_d, vs_rise, de_rise;
  logic [7:0]  frame_cnt;
  logic [15:0] line_cnt;
  logic [15:0] line_drop_cnt;
  wr_state_t   wr_state, wr_state_nxt;
  logic [8:0]  wcnt;
  logic [15:0] half;
  logic        ph;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        line_done, line_drop, free_ok;
  logic [AW:0] fifo_used;
  logic        fifo_empty;
  logic [31:0] fifo_rd_data;
  logic [AW:0] lines_ready;
  logic        underrun;
  tx_state_t   tx_state, tx_state_nxt;
  logic [15:0] gap_cnt;
  logic        tx_start;

  assign vs_rise = bus.vs_in & ~vs_d;
  assign de_rise = bus.de_in & ~de_d;
  assign free_ok = (DEPTH_CNT - fifo_used) >= NEED_FREE;

  sync_fifo_32 #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_wr_data),
    .rd_en   (bus.tx_req),
    .rd_data (fifo_rd_data),
    .used    (fifo_used),
    .empty   (fifo_empty)
  );

  always_comb begin
    wr_state_nxt = wr_state;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    line_done    = 1'b0;
    line_drop    = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (de_rise) begin
          if (free_ok) begin
            fifo_wr_en   = 1'b1;
            fifo_wr_data = {HDR_TAG, frame_cnt, line_cnt};
            wr_state_nxt = WR_DATA;
          end else begin
            line_drop = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (bus.de_in) begin
          if (ph) begin
            fifo_wr_en   = 1'b1;
            fifo_wr_data = {half, bus.pix_data};
          end
        end else begin
          // de_in fell early: flush the pending half (zero-filled) or a zero word
          fifo_wr_en   = 1'b1;
          fifo_wr_data = ph ? {half, 16'h0000} : 32'h0;
        end
      end
      WR_PAD: begin
        fifo_wr_en = 1'b1;
        line_drop  = de_rise;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
    if (wr_state != WR_IDLE && fifo_wr_en && wcnt == LAST_WORD) begin
      line_done    = 1'b1;
      wr_state_nxt = WR_IDLE;
    end else if (wr_state == WR_DATA && !bus.de_in) begin
      wr_state_nxt = WR_PAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Edge detectors start high so a line or frame already active at
      // release is not mistaken for a new one.
      vs_d          <= 1'b1;
      de_d          <= 1'b1;
      frame_cnt     <= '0;
      line_cnt      <= '0;
      line_drop_cnt <= '0;
      wr_state      <= WR_IDLE;
      wcnt          <= '0;
      half          <= '0;
      ph            <= 1'b0;
      lines_ready   <= '0;
      underrun      <= 1'b0;
    end else begin
      vs_d     <= bus.vs_in;
      de_d     <= bus.de_in;
      wr_state <= wr_state_nxt;
      if (vs_rise) begin
        line_cnt  <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (de_rise) begin
        line_cnt <= line_cnt + 16'd1;
      end
      if (line_drop && line_drop_cnt != 16'hFFFF) line_drop_cnt <= line_drop_cnt + 16'd1;
      // While idle the pixel is latched every cycle, so the first pixel of an
      // accepted line is already held when the header is written.
      if (wr_state == WR_IDLE) begin
        wcnt <= '0;
        ph   <= 1'b1;
        half <= bus.pix_data;
      end else if (fifo_wr_en) begin
        wcnt <= wcnt + 9'd1;
        ph   <= 1'b0;
      end else if (bus.de_in) begin
        half <= bus.pix_data;
        ph   <= 1'b1;
      end
      lines_ready <= lines_ready + (AW+1)'(line_done) - (AW+1)'(tx_start);
      underrun    <= underrun | (bus.tx_req & fifo_empty);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      gap_cnt  <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_state == TX_BUSY && bus.udp_tx_done) gap_cnt <= GAP_LOAD;
      else if (tx_state == TX_GAP && gap_cnt != 16'd0) gap_cnt <= gap_cnt - 16'd1;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_start     = 1'b0;
    case (tx_state)
      TX_IDLE:  if (lines_ready != '0) tx_state_nxt = TX_START;
      TX_START: begin
        tx_start     = 1'b1;
        tx_state_nxt = TX_BUSY;
      end
      TX_BUSY:  if (bus.udp_tx_done) tx_state_nxt = TX_GAP;
      TX_GAP:   if (gap_cnt == 16'd0) tx_state_nxt = TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  assign bus.udp_tx_start_en = tx_start;
  assign bus.tx_byte_num     = calc_tx_byte_num(H_PIXELS);
  assign bus.tx_data         = fifo_rd_data;
  assign bus.line_drop_cnt   = line_drop_cnt;
endmodule

// File: doc/video_udp_packetizer.md
VIDEO_UDP_PACKETIZER -- requirements
Module: video_udp_packetizer

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, meaning RGB565 pixels per line; even, 2..732.
REQ-002 SHALL have parameter FIFO_DEPTH, default 1024, meaning 32-bit words of line buffer; power of two, at least H_PIXELS/2+1.
REQ-003 SHALL have parameter IFG_CYCLES, default 16, meaning idle clk cycles between udp_tx_done and the next start.
REQ-004 SHALL have port clk, input, 1, system clock; all logic is in this single domain.
REQ-005 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have ports vs_in and de_in, inputs, 1 each, frame sync and data enable, synchronous to clk.
REQ-007 SHALL have port pix_data, input, 16, pixel, sampled when de_in=1.
REQ-008 SHALL have port udp_tx_start_en, output, 1, one-cycle start pulse to the UDP transmitter and protocol controller.
REQ-009 SHALL have port tx_byte_num, output, 16, UDP payload length, constant 4+2*H_PIXELS.
REQ-010 SHALL have port tx_req, input, 1, read request from the UDP transmitter.
REQ-011 SHALL have port tx_data, output, 32, payload word.
REQ-012 SHALL have port udp_tx_done, input, 1, end-of-packet pulse.
REQ-013 SHALL have port line_drop_cnt, output, 16, count of dropped lines, saturating.

Function
REQ-014 Each rising edge of vs_in SHALL clear line_cnt[15:0] to 0 and increment frame_cnt[7:0], wrapping 255 to 0.
REQ-015 On a de_in rising edge, if free FIFO words are at least H_PIXELS/2+1, the writer SHALL accept the line; otherwise it SHALL drop the whole line and increment line_drop_cnt.
REQ-016 For an accepted line, the writer SHALL first write the header {8'hA5, frame_cnt, line_cnt}, then pixel pairs packed as {first pixel[31:16], second pixel[15:0]}.
REQ-017 Short line (de_in falls before H_PIXELS pixels): the writer SHALL complete the pending half-word with zeros, then write one zero word per cycle until H_PIXELS/2 data words are written.
REQ-018 Long line: pixels beyond H_PIXELS SHALL be discarded.
REQ-019 A de_in rising edge that occurs while padding is in progress SHALL drop that line and increment line_drop_cnt.
REQ-020 line_cnt SHALL increment once per de_in rising edge, whether the line is accepted or dropped.
REQ-021 Once the last word of an accepted line is written, lines_ready SHALL increment.
REQ-022 Sender FSM states:
- IDLE: if lines_ready>0, go to START.
- START: assert udp_tx_start_en for exactly 1 cycle, decrement lines_ready, go to BUSY.
- BUSY: on udp_tx_done, go to GAP.
- GAP: count IFG_CYCLES cycles, then go to IDLE.
REQ-023 If lines_ready increments and decrements in the same cycle, its value SHALL remain unchanged.
REQ-024 Each tx_req cycle SHALL pop one FIFO word; tx_data SHALL be valid on the following cycle and SHALL hold its value otherwise.
REQ-025 A tx_req while the FIFO is empty SHALL NOT pop; tx_data SHALL hold, and the sticky internal flag underrun SHALL set.
REQ-026 Start-to-first-tx_req latency SHALL be unconstrained; the module SHALL NOT issue a second start before udp_tx_done.
REQ-027 A udp_tx_done outside BUSY SHALL be ignored.

Reset
REQ-028 While rst_n=0, the module SHALL hold: udp_tx_start_en=0, tx_data=0, line_drop_cnt=0, FSM=IDLE, FIFO empty, lines_ready=0, line_cnt=0, frame_cnt=0, writer idle.
REQ-029 Reset asserted mid-line or mid-packet SHALL discard all buffered data; after release, the first accepted line SHALL start at a de_in rising edge.

Structure
REQ-030 A shared package SHALL hold the header tag 8'hA5, the FSM state encoding, and a function computing tx_byte_num from H_PIXELS.
REQ-031 The design SHALL have one sub-module, sync_fifo_32 (parameterised depth, 1-cycle read latency, exposing a used-word count); the writer and the sender FSM stay in the top module.

Verification
REQ-032 H_PIXELS=8, one vs pulse, one line of pixels 0x0001..0x0008 -> one start pulse; tx_byte_num=20; words A5010000, 00010002, 00030004, 00050006, 00070008.
REQ-033 Three back-to-back lines, udp_tx_done returned 50 cycles after each start -> 3 starts, each separated by at least 16 cycles after done; headers carry line_cnt 0, 1, 2.
REQ-034 Short line of 3 pixels, H_PIXELS=8 -> words: header, 00010002, 00030000, 00000000, 00000000.
REQ-035 FIFO_DEPTH=16, H_PIXELS=8, four lines with no tx_req -> lines 0-2 accepted, line 3 dropped; line_drop_cnt=1.
REQ-036 rst_n pulsed low during the 3rd payload word -> all outputs at reset values; next line header frame_cnt equals the number of vs edges since release.
